// File: rtl/clk_div_prog_if.sv
// Control and status bundle for the programmable clock divider.
// load is a one-cycle strobe with no back-pressure: every sampled load is accepted.
interface clk_div_prog_if #(
    parameter int W = 8
);
    logic         en;
    logic         load;
    logic [W-1:0] div_val;
    logic         clk_out;
    logic         tick;
    logic         busy;
    logic [W-1:0] cur_div;
    logic         state_dbg;

    modport master (
        output en, load, div_val,
        input  clk_out, tick, busy, cur_div, state_dbg
    );

    modport slave (
        input  en, load, div_val,
        output clk_out, tick, busy, cur_div, state_dbg
    );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable clock divider with 50% duty for even and odd divisors.
// Divisor changes are staged in a pending register and applied only at period boundaries.
module clk_div_prog #(
    parameter int W       = 8,
    parameter int DEF_DIV = 7
) (
    input  logic             clk_in,
    input  logic             rst_n,
    clk_div_prog_if.slave    bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [W-1:0] DEF = W'(DEF_DIV);
    localparam logic [W-1:0] TWO = W'(2);
    localparam logic [W-1:0] ONE = W'(1);

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] n_act_q, n_act_d;
    logic [W-1:0] pend_q, pend_d;
    logic         pend_v_q, pend_v_d;
    logic         clk_p_q, clk_p_d;
    logic         tick_q, tick_d;
    logic         clk_n_q;

    logic [W-1:0] div_clamped;
    logic [W-1:0] cnt_inc;
    logic [W-1:0] half_n;
    logic         period_end;

    assign div_clamped = (bus.div_val < TWO) ? TWO : bus.div_val;
    assign cnt_inc     = cnt_q + ONE;
    assign half_n      = n_act_q >> 1;
    assign period_end  = (cnt_q == (n_act_q - ONE));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            n_act_q  <= DEF;
            pend_q   <= DEF;
            pend_v_q <= 1'b0;
            clk_p_q  <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_act_q  <= n_act_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            clk_p_q  <= clk_p_d;
            tick_q   <= tick_d;
        end
    end

    // Half-cycle delayed copy of clk_p; stretches the high phase by half a cycle for odd N.
    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) clk_n_q <= 1'b0;
        else        clk_n_q <= clk_p_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_act_d  = n_act_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        clk_p_d  = clk_p_q;
        tick_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                clk_p_d = 1'b0;
                if (bus.en) begin
                    state_d = RUN;
                    clk_p_d = 1'b1;
                    tick_d  = 1'b1;
                    if (pend_v_q) begin
                        n_act_d  = pend_q;
                        pend_v_d = 1'b0;
                    end
                end
            end
            RUN: begin
                if (!period_end) begin
                    cnt_d   = cnt_inc;
                    clk_p_d = (cnt_inc < half_n);
                end else if (bus.en) begin
                    cnt_d   = '0;
                    clk_p_d = 1'b1;
                    tick_d  = 1'b1;
                    if (pend_v_q) begin
                        n_act_d  = pend_q;
                        pend_v_d = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    clk_p_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A load on a boundary edge lands after the swap above, so it waits for the next boundary.
        if (bus.load) begin
            pend_d   = div_clamped;
            pend_v_d = 1'b1;
        end
    end

    always_comb begin
        bus.clk_out   = clk_p_q | (clk_n_q & n_act_q[0]);
        bus.tick      = tick_q;
        bus.busy      = (state_q == RUN);
        bus.cur_div   = n_act_q;
        bus.state_dbg = logic'(state_q);
    end
endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter W, default 8: width of divisor and counter; legal range W >= 2.
REQ-002 Parameter DEF_DIV, default 7: divisor loaded at reset; legal range 2..2^W-1.
REQ-003 clk_in  input  1  source clock; all logic on posedge except the odd-extend flop (negedge).
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  run request; sampled on posedge clk_in.
REQ-006 div_val  input  W  requested divisor N.
REQ-007 load  input  1  single-cycle strobe; captures div_val into the pending register.
REQ-008 clk_out  output  1  divided clock, 50% duty for even and odd N.
REQ-009 tick  output  1  one-clk_in-cycle pulse, high in the first cycle of each output period.
REQ-010 busy  output  1  high while in RUN.
REQ-011 cur_div  output  W  divisor currently in effect (N_act).

Function
REQ-012 States IDLE and RUN; internal cnt (W bits), N_act, pending, pend_valid, clk_p (posedge), clk_n (negedge).
REQ-013 Clamp rule: div_val 0 or 1 stored as 2 wherever captured.
REQ-014 load=1 at a posedge: pending <= clamp(div_val), pend_valid <= 1; repeated loads mean last wins.
REQ-015 IDLE: clk_p = 0, cnt = 0, tick = 0; at posedge with en=1: N_act <= pending if pend_valid (pend_valid <= 0), else N_act kept; cnt <= 0; clk_p <= 1; tick <= 1; state <= RUN.
REQ-016 RUN, cnt != N_act-1: cnt <= cnt+1; clk_p <= 1 iff (cnt+1) < floor(N_act/2); tick <= 0.
REQ-017 RUN, cnt == N_act-1 (period end), en=1: cnt <= 0, clk_p <= 1, tick <= 1, N_act <= pending if pend_valid (clear pend_valid).
REQ-018 RUN, period end, en=0: state <= IDLE, clk_p <= 0, cnt <= 0; the in-progress period always completes in full.
REQ-019 en deassert mid-period has no effect before period end.
REQ-020 clk_n <= clk_p on every negedge clk_in.
REQ-021 odd flag = N_act[0]; clk_out = clk_p | (clk_n & odd).
REQ-022 Even N: clk_out high N/2 cycles, low N/2 cycles.
REQ-023 Odd N: clk_out high (N/2) cycles (including the half-cycle extension), low the same.
REQ-024 Divisor and odd/even changes take effect only at a period boundary, with no output pulse narrower than floor(N/2) clk_in cycles for either the old or new N.
REQ-025 load coincident with a period-end edge updates pending only; that value applies at the following boundary.
REQ-026 Latency: clk_out rises 1 posedge after en is first sampled high in IDLE.
REQ-027 busy = (state == RUN); cur_div = N_act.

Reset
REQ-028 rst_n low, asynchronously: state IDLE, cnt 0, clk_p 0, clk_n 0, tick 0, N_act = DEF_DIV, pending = DEF_DIV, pend_valid 0.
REQ-029 After reset: clk_out 0, busy 0, cur_div = DEF_DIV.
REQ-030 Reset asserted mid-period forces clk_out low immediately, with no wait for clk_in.
REQ-031 Operation resumes only via the IDLE en=1 path after rst_n rises.

Verification
REQ-032 Reset, en=1, DEF_DIV=7 -> clk_out period 7 cycles, high 3.5 / low 3.5, tick every 7 cycles, cur_div=7.
REQ-033 load div_val=4 in IDLE, then en=1 -> high 2 / low 2, period 4, no extension from clk_n.
REQ-034 Running N=4, load div_val=5 at cnt=1 -> current 4-cycle period completes, then periods of 5 (high 2.5 / low 2.5); cur_div changes to 5 at the boundary.
REQ-035 Running N=6, en=0 at cnt=2 -> period finishes at cnt=5, then clk_out=0, busy=0 from the next cycle.
REQ-036 load div_val=0 then div_val=1 -> cur_div=2 after the next boundary, clk_out toggles every cycle.
REQ-037 rst_n low mid-period with N=9 -> clk_out, tick, busy 0 within the reset assertion, cur_div=DEF_DIV.
